// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-port signals of mem_ctrl. The controller uses the slave
// modport; the requesters and the RAM sit on the master side.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH  = 17,
    parameter int BLOCK_WIDTH = 4
);
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;

    logic                              instrReq;
    logic [ADDR_WIDTH-1:BLOCK_WIDTH]   instrAddr;
    logic                              instrDataValid;
    logic [ADDR_WIDTH-1:BLOCK_WIDTH]   instrBlockAddr;
    logic [BLOCK_SIZE*8-1:0]           instrData;

    logic                              dataReq;
    logic                              dataWrite;
    logic [1:0]                        dataSize;
    logic [ADDR_WIDTH-1:0]             dataAddr;
    logic [31:0]                       dataIn;
    logic                              dataValid;
    logic [31:0]                       dataOut;

    logic [7:0]                        memIn;
    logic [7:0]                        memOut;
    logic [ADDR_WIDTH-1:0]             memAddr;
    logic                              memWrite;

    modport slave (
        input  instrReq, instrAddr, dataReq, dataWrite, dataSize, dataAddr, dataIn, memIn,
        output instrDataValid, instrBlockAddr, instrData, dataValid, dataOut,
               memOut, memAddr, memWrite
    );

    modport master (
        output instrReq, instrAddr, dataReq, dataWrite, dataSize, dataAddr, dataIn, memIn,
        input  instrDataValid, instrBlockAddr, instrData, dataValid, dataOut,
               memOut, memAddr, memWrite
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between icache block refills and 1/2/4-byte loads/stores.
// Optional MEM_CTRL_RR_EN: round-robin arbitration on contention (default: data beats instruction).
//
// state    | meaning
// S_IDLE   | sample requests, arbitrate, latch base/count/store data/owner
// S_IFETCH | serial block refill read, cnt 0..N
// S_DREAD  | serial load read, cnt 0..N
// S_DWRITE | serial store, one byte per cycle, cnt 0..N-1
// S_DONE   | owner's valid pulse, then back to idle
module mem_ctrl #(
    parameter int ADDR_WIDTH  = 17,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic       clkIn,
    input  logic       resetIn,
    input  logic       readyIn,
    input  logic       flushIn,
    mem_ctrl_if.slave  bus
);
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
    localparam int CNT_W      = BLOCK_WIDTH + 1;
    localparam int LINE_W     = BLOCK_SIZE * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFETCH,
        S_DREAD,
        S_DWRITE,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        n_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [31:0]             wdata_q;
    logic [LINE_W-1:0]       line_q;

    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [7:0]              mem_out_q;
    logic                    mem_we_q;
    logic                    iv_q;
    logic                    dv_q;
    logic [LINE_W-1:0]       idata_q;
    logic [ADDR_WIDTH-1:BLOCK_WIDTH] iblk_q;
    logic [31:0]             dout_q;
`ifdef MEM_CTRL_RR_EN
    logic                    last_instr_q;
`endif

    logic [CNT_W-1:0]        cnt_inc;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [BLOCK_WIDTH-1:0]  byte_idx;
    logic [LINE_W-1:0]       line_d;
    logic [7:0]              wbyte_d;
    logic [CNT_W-1:0]        dn_d;
    logic                    pick_data;
    logic                    pick_instr;

    always_comb begin
        cnt_inc  = cnt_q + CNT_W'(1);
        addr_nxt = base_q + ADDR_WIDTH'(cnt_inc);
        // memIn carries the byte addressed one cycle earlier
        byte_idx = cnt_q[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);
        line_d   = line_q;
        line_d[{byte_idx, 3'b000} +: 8] = bus.memIn;
        wbyte_d  = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];

        case (bus.dataSize)
            2'd0:    dn_d = CNT_W'(1);
            2'd1:    dn_d = CNT_W'(2);
            default: dn_d = CNT_W'(4);
        endcase

`ifdef MEM_CTRL_RR_EN
        pick_data = bus.dataReq & (~bus.instrReq | last_instr_q);
`else
        pick_data = bus.dataReq;
`endif
        pick_instr = bus.instrReq & ~pick_data;
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
            mem_addr_q <= '0;
            mem_out_q  <= '0;
            mem_we_q   <= 1'b0;
            iv_q       <= 1'b0;
            dv_q       <= 1'b0;
            idata_q    <= '0;
            iblk_q     <= '0;
            dout_q     <= '0;
`ifdef MEM_CTRL_RR_EN
            last_instr_q <= 1'b0;
`endif
        end else if (state_q == S_IFETCH && flushIn) begin
            // a flush is honoured even under a stall so it can never be lost
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (readyIn) begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (pick_instr) begin
                        state_q    <= S_IFETCH;
                        base_q     <= {bus.instrAddr, {BLOCK_WIDTH{1'b0}}};
                        mem_addr_q <= {bus.instrAddr, {BLOCK_WIDTH{1'b0}}};
                        n_q        <= CNT_W'(BLOCK_SIZE);
                        line_q     <= '0;
`ifdef MEM_CTRL_RR_EN
                        last_instr_q <= 1'b1;
`endif
                    end else if (pick_data) begin
                        state_q    <= bus.dataWrite ? S_DWRITE : S_DREAD;
                        base_q     <= bus.dataAddr;
                        mem_addr_q <= bus.dataAddr;
                        n_q        <= dn_d;
                        wdata_q    <= bus.dataIn;
                        line_q     <= '0;
                        if (bus.dataWrite) begin
                            mem_we_q  <= 1'b1;
                            mem_out_q <= bus.dataIn[7:0];
                        end
`ifdef MEM_CTRL_RR_EN
                        last_instr_q <= 1'b0;
`endif
                    end
                end

                S_IFETCH, S_DREAD: begin
                    if (cnt_q != '0) begin
                        line_q <= line_d;
                    end
                    if (cnt_q == n_q) begin
                        state_q <= S_DONE;
                        if (state_q == S_IFETCH) begin
                            idata_q <= line_d;
                            iblk_q  <= base_q[ADDR_WIDTH-1:BLOCK_WIDTH];
                            iv_q    <= 1'b1;
                        end else begin
                            dout_q <= line_d[31:0];
                            dv_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q      <= cnt_inc;
                        mem_addr_q <= addr_nxt;
                    end
                end

                S_DWRITE: begin
                    if (cnt_inc == n_q) begin
                        state_q  <= S_DONE;
                        mem_we_q <= 1'b0;
                        dv_q     <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_inc;
                        mem_addr_q <= addr_nxt;
                        mem_out_q  <= wbyte_d;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    iv_q    <= 1'b0;
                    dv_q    <= 1'b0;
                end

                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memAddr        = mem_addr_q;
    assign bus.memOut         = mem_out_q;
    assign bus.memWrite       = mem_we_q & readyIn;
    assign bus.instrDataValid = iv_q;
    assign bus.instrBlockAddr = iblk_q;
    assign bus.instrData      = idata_q;
    assign bus.dataValid      = dv_q;
    assign bus.dataOut        = dout_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus random loads/stores/refills against a byte-array model.
module tb_mem_ctrl;
    localparam int AW = 17;
    localparam int MEMSZ = 1 << AW;
`ifdef MEM_CTRL_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clkIn = 1'b0;
    logic resetIn;
    logic readyIn;
    logic flushIn;

    always #5 clkIn = ~clkIn;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clkIn   (clkIn),
        .resetIn (resetIn),
        .readyIn (readyIn),
        .flushIn (flushIn),
        .bus     (bus)
    );

    logic [7:0]    ram [0:MEMSZ-1];
    logic [7:0]    mdl [0:MEMSZ-1];
    bit            ram_ready = 1'b0;
    logic [AW+7:0] wlog [$];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [7:0] init_byte(input int a);
        if (a == 32'h102) return 8'h80;
        if (a == 32'h103) return 8'h7F;
        return a[7:0];
    endfunction

    // RAM: one-cycle read latency, frozen together with the controller when readyIn is low
    always @(posedge clkIn) begin
        if (!ram_ready) begin
            for (int i = 0; i < MEMSZ; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (readyIn) begin
            if (bus.memWrite) ram[bus.memAddr] <= bus.memOut;
            bus.memIn <= ram[bus.memAddr];
        end
    end

    always @(posedge clkIn) begin
        if (bus.memWrite) wlog.push_back({bus.memAddr, bus.memOut});
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    function automatic logic [127:0] exp_line(input logic [AW-5:0] blk);
        logic [127:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = mdl[{blk, 4'(i)}];
        return l;
    endfunction

    // one load/store from an idle cycle; readyIn low during cycles s..s+len-1
    task automatic data_op(input bit wr, input logic [1:0] sz, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input int s, input int len, input string tag);
        int n, lat, cyc;
        bit got;
        logic [31:0] exp_rd;
        logic [AW-1:0] a;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lat = wr ? n + 1 : n + 2;
        exp_rd = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + AW'(i);
            exp_rd[8*i +: 8] = mdl[a];
        end
        wlog.delete();
        bus.dataReq = 1'b1;
        bus.dataWrite = wr;
        bus.dataSize = sz;
        bus.dataAddr = addr;
        bus.dataIn = wd;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 64) begin
            tick();
            cyc++;
            readyIn = !(cyc >= s && cyc < s + len);
            #1;
            if (!readyIn) check({tag, "_stall_we"}, {127'b0, bus.memWrite}, 128'd0);
            got = bus.dataValid;
        end
        check({tag, "_lat"}, 128'(cyc), 128'(lat + len));
        if (!wr) check({tag, "_rd"}, {96'b0, bus.dataOut}, {96'b0, exp_rd});
        tick();
        bus.dataReq = 1'b0;
        if (wr) begin
            check({tag, "_wcnt"}, 128'(wlog.size()), 128'(n));
            for (int i = 0; i < n; i++) begin
                a = addr + AW'(i);
                if (i < wlog.size())
                    check({tag, "_wbyte"}, {103'b0, wlog[i]}, {103'b0, a, wd[8*i +: 8]});
                mdl[a] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic refill(input logic [AW-5:0] blk, input string tag);
        int cyc;
        logic [127:0] exp;
        exp = exp_line(blk);
        bus.instrReq = 1'b1;
        bus.instrAddr = blk;
        cyc = 0;
        while (!bus.instrDataValid && cyc < 64) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 128'(cyc), 128'd18);
        check({tag, "_data"}, bus.instrData, exp);
        check({tag, "_blk"}, {115'b0, bus.instrBlockAddr}, {115'b0, blk});
        tick();
        bus.instrReq = 1'b0;
    endtask

    initial begin
        int cyc, dvcyc, t, il, dl, done, ileft, n_obs;
        bit saw_iv, last_i, pick_i, iprev, dprev;
        int exp_q [$];
        int obs_q [$];
        logic [AW-5:0] blk2;
        logic [AW-1:0] ra;
        logic [1:0] rsz;
        int rlen, rs, rn;

        for (int i = 0; i < MEMSZ; i++) mdl[i] = init_byte(i);
        resetIn = 1'b0;
        readyIn = 1'b1;
        flushIn = 1'b0;
        bus.instrReq = 1'b0;
        bus.instrAddr = '0;
        bus.dataReq = 1'b0;
        bus.dataWrite = 1'b0;
        bus.dataSize = 2'd0;
        bus.dataAddr = '0;
        bus.dataIn = '0;

        repeat (3) @(posedge clkIn);
        #1;
        check("rst_memAddr", {111'b0, bus.memAddr}, 128'd0);
        check("rst_memOut", {120'b0, bus.memOut}, 128'd0);
        check("rst_memWrite", {127'b0, bus.memWrite}, 128'd0);
        check("rst_ivalid", {127'b0, bus.instrDataValid}, 128'd0);
        check("rst_dvalid", {127'b0, bus.dataValid}, 128'd0);
        check("rst_idata", bus.instrData, 128'd0);
        check("rst_iblk", {115'b0, bus.instrBlockAddr}, 128'd0);
        check("rst_dout", {96'b0, bus.dataOut}, 128'd0);
        @(negedge clkIn);
        resetIn = 1'b1;
        tick();

        refill(13'h0040, "refill40");
        data_op(1'b1, 2'd2, 17'h1FFFE, 32'hDEADBEEF, 0, 0, "st_wrap");
        data_op(1'b0, 2'd1, 17'h00102, 32'h0, 0, 0, "ld_half");
        data_op(1'b0, 2'd2, 17'h1FFFE, 32'h0, 0, 0, "ld_wrap");
        data_op(1'b0, 2'd0, 17'h00405, 32'h0, 0, 0, "ld_byte");
        data_op(1'b1, 2'd0, 17'h00200, 32'h000000A5, 0, 0, "st_byte");
        data_op(1'b0, 2'd2, 17'h001FE, 32'h0, 2, 3, "ld_stall");

        // flush during IFETCH cnt 7 with a load waiting behind the refill
        bus.instrReq = 1'b1;
        bus.instrAddr = 13'h0055;
        cyc = 0;
        dvcyc = -1;
        saw_iv = 1'b0;
        while (cyc < 30) begin
            tick();
            cyc++;
            if (cyc == 3) begin
                bus.dataReq = 1'b1;
                bus.dataWrite = 1'b0;
                bus.dataSize = 2'd0;
                bus.dataAddr = 17'h00200;
            end
            if (cyc == 8) flushIn = 1'b1;
            if (cyc == 9) begin
                flushIn = 1'b0;
                bus.instrReq = 1'b0;
            end
            if (dvcyc >= 0 && cyc == dvcyc + 1) bus.dataReq = 1'b0;
            #1;
            if (bus.instrDataValid) saw_iv = 1'b1;
            if (bus.dataValid && dvcyc < 0) begin
                dvcyc = cyc;
                check("flush_dout", {96'b0, bus.dataOut}, {120'b0, mdl[17'h00200]});
            end
        end
        check("flush_no_ivalid", {127'b0, saw_iv}, 128'd0);
        check("flush_dv_cycle", 128'(dvcyc), 128'd12);
        tick();

        // asynchronous reset in the middle of a word load
        bus.dataReq = 1'b1;
        bus.dataWrite = 1'b0;
        bus.dataSize = 2'd2;
        bus.dataAddr = 17'h00300;
        tick();
        tick();
        tick();
        #2;
        resetIn = 1'b0;
        #1;
        check("mrst_memAddr", {111'b0, bus.memAddr}, 128'd0);
        check("mrst_dout", {96'b0, bus.dataOut}, 128'd0);
        check("mrst_idata", bus.instrData, 128'd0);
        check("mrst_dvalid", {127'b0, bus.dataValid}, 128'd0);
        bus.dataReq = 1'b0;
        @(negedge clkIn);
        resetIn = 1'b1;
        tick();
        last_i = 1'b0;

        // contention: two back-to-back refills and one half load, all raised together
        t = 0;
        il = 2;
        dl = 1;
        while (il > 0 || dl > 0) begin
            if (il > 0 && dl > 0) pick_i = RR ? !last_i : 1'b0;
            else pick_i = (il > 0);
            done = t + (pick_i ? 18 : 4);
            exp_q.push_back((pick_i ? 1000 : 0) + done);
            t = done + 1;
            last_i = pick_i;
            if (pick_i) il--;
            else dl--;
        end
        blk2 = 13'h0123;
        bus.instrReq = 1'b1;
        bus.instrAddr = blk2;
        bus.dataReq = 1'b1;
        bus.dataWrite = 1'b0;
        bus.dataSize = 2'd1;
        bus.dataAddr = 17'h00102;
        ileft = 2;
        iprev = 1'b0;
        dprev = 1'b0;
        cyc = 0;
        while ((ileft > 0 || bus.dataReq) && cyc < 120) begin
            tick();
            cyc++;
            if (iprev) begin
                iprev = 1'b0;
                if (ileft == 0) bus.instrReq = 1'b0;
                else begin
                    blk2 = 13'h1FFF;
                    bus.instrAddr = blk2;
                end
            end
            if (dprev) begin
                dprev = 1'b0;
                bus.dataReq = 1'b0;
            end
            if (bus.instrDataValid) begin
                obs_q.push_back(1000 + cyc);
                check("cont_idata", bus.instrData, exp_line(blk2));
                ileft--;
                iprev = 1'b1;
            end
            if (bus.dataValid) begin
                obs_q.push_back(cyc);
                check("cont_dout", {96'b0, bus.dataOut}, 128'h7F80);
                dprev = 1'b1;
            end
        end
        n_obs = obs_q.size();
        check("cont_count", 128'(n_obs), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_obs) check("cont_order", 128'(obs_q[i]), 128'(exp_q[i]));
        end
        tick();
        bus.instrReq = 1'b0;
        bus.dataReq = 1'b0;
        tick();

        // random traffic
        for (int k = 0; k < 40; k++) begin
            rn = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) ra = 17'h1FFFF - AW'($urandom_range(0, 3));
            else ra = AW'($urandom);
            if (rn == 0) begin
                refill(ra[AW-1:4], "rnd_refill");
            end else begin
                rsz = 2'($urandom_range(0, 3));
                rlen = $urandom_range(0, 3);
                rs = $urandom_range(1, (rsz == 2'd0) ? 1 : (rsz == 2'd1) ? 2 : 4);
                data_op(rn > 2, rsz, ra, $urandom, rs, rlen, (rn > 2) ? "rnd_st" : "rnd_ld");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
